// File: rtl/s2p_converter.sv
// -----------------------------------------------------------------------------
// s2p_converter
//
// Serial-to-parallel deserialiser. Collects N serial bits into a word and
// presents it on a valid/ready parallel interface. One finished word can sit
// in the output register while a second finished word waits in the shift
// register. The serial side therefore keeps streaming through short
// parallel-side stalls.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   ser_data   serial data bit
//   ser_valid  ser_data is valid this cycle
//   ser_ready  a serial bit is accepted this cycle (registered state only)
//   par_data   reassembled word, stable while par_valid & !par_ready
//   par_valid  par_data holds a complete word
//   par_ready  downstream accepts par_data this cycle
//   bit_cnt    bits collected toward the current word
//   fsm_state  debug view of the FSM (0 = COLLECT, 1 = HOLD)
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. A valid producer holds its data until that
// edge. ready never depends combinationally on the other side's ready.
// -----------------------------------------------------------------------------
module s2p_converter #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ser_data,
    input  logic          ser_valid,
    output logic          ser_ready,
    output logic [N-1:0]  par_data,
    output logic          par_valid,
    input  logic          par_ready,
    output logic [CW-1:0] bit_cnt,
    output logic          fsm_state
);

    localparam logic [0:0]    COLLECT = 1'b0;
    localparam logic [0:0]    HOLD    = 1'b1;
    localparam logic [CW-1:0] LAST    = CW'(N - 1);

    logic [0:0]    r_state;
    logic [N-1:0]  r_shift;
    logic [CW-1:0] r_bit_cnt;
    logic [N-1:0]  r_par_data;
    logic          r_par_valid;

    logic          w_accept;
    logic          w_xfer;
    logic          w_last;
    logic          w_slot_free;
    logic [CW-1:0] w_idx;
    logic [N-1:0]  w_next_shift;

    // ser_ready is forced low while reset is held. It rises as soon as reset
    // is released.
    assign ser_ready   = (r_state == COLLECT) && !rst;
    assign w_accept    = ser_valid && ser_ready;
    assign w_xfer      = r_par_valid && par_ready;
    assign w_last      = (r_bit_cnt == LAST);
    // The output slot is free when it is empty, or when it empties on this edge.
    assign w_slot_free = !r_par_valid || par_ready;
    assign w_idx       = MSB_FIRST ? (LAST - r_bit_cnt) : r_bit_cnt;

    // The shift register is cleared between words, so each bit is placed at
    // its final position. Nothing is shifted along.
    always_comb begin
        w_next_shift        = r_shift;
        w_next_shift[w_idx] = ser_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_data  <= '0;
            r_par_valid <= 1'b0;
        end else begin
            // A transfer empties the slot unless a reload below refills it
            // on this same edge.
            if (w_xfer) begin
                r_par_valid <= 1'b0;
            end
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_bit_cnt <= '0;
                            if (w_slot_free) begin
                                r_par_data  <= w_next_shift;
                                r_par_valid <= 1'b1;
                                r_shift     <= '0;
                            end else begin
                                r_shift <= w_next_shift;
                                r_state <= HOLD;
                            end
                        end else begin
                            r_shift   <= w_next_shift;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_xfer) begin
                        r_par_data  <= r_shift;
                        r_par_valid <= 1'b1;
                        r_shift     <= '0;
                        r_state     <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign par_data  = r_par_data;
    assign par_valid = r_par_valid;
    assign bit_cnt   = r_bit_cnt;
    assign fsm_state = r_state;

endmodule

// File: tb/tb_s2p_converter.sv
// -----------------------------------------------------------------------------
// tb_s2p_converter
//
// Drives two instances of s2p_converter:
//   dut0  N=4, LSB first
//   dut1  N=4, MSB first
// Each test pushes its hand-computed words into a per-instance expected
// queue. A monitor for each instance pops a word and compares it whenever
// par_valid & par_ready is seen.
// -----------------------------------------------------------------------------
module tb_s2p_converter;

    logic       clk = 1'b0;
    logic       rst;

    logic       s0_data, s0_valid, s0_ready, s0_pvalid, s0_pready, s0_state;
    logic [3:0] s0_pdata;
    logic [1:0] s0_cnt;

    logic       s1_data, s1_valid, s1_ready, s1_pvalid, s1_pready, s1_state;
    logic [3:0] s1_pdata;
    logic [1:0] s1_cnt;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    int         xfer_q[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int stall_cnt = 0;

    s2p_converter #(.N(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .ser_data(s0_data), .ser_valid(s0_valid), .ser_ready(s0_ready),
        .par_data(s0_pdata), .par_valid(s0_pvalid), .par_ready(s0_pready),
        .bit_cnt(s0_cnt), .fsm_state(s0_state)
    );

    s2p_converter #(.N(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .ser_data(s1_data), .ser_valid(s1_valid), .ser_ready(s1_ready),
        .par_data(s1_pdata), .par_valid(s1_pvalid), .par_ready(s1_pready),
        .bit_cnt(s1_cnt), .fsm_state(s1_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one bit and hold it until accepted. Return #1 after the accepting edge.
    task automatic send_bit(input int d, input logic b);
        int   waited;
        logic acc;
        waited = 0;
        if (d == 0) begin s0_valid = 1'b1; s0_data = b; end
        else        begin s1_valid = 1'b1; s1_data = b; end
        while (1) begin
            acc = (d == 0) ? s0_ready : s1_ready;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 100) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (d == 0) begin s0_valid = 1'b0; s0_data = 1'bx; end
        else        begin s1_valid = 1'b0; s1_data = 1'bx; end
    endtask

    // seq[0] is sent first. gap is the number of idle cycles between bits.
    task automatic send_seq(input int d, input logic [3:0] seq, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_bit(d, seq[k]);
            if (k < 3) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    logic       prev_stall0;
    logic [3:0] prev_data0;

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst) begin
            prev_stall0 = 1'b0;
        end else begin
            if (prev_stall0 && s0_pvalid) check("dut0_hold_stable", s0_pdata, prev_data0);
            if (s0_pvalid && s0_pready) begin
                if (exp_q0.size() == 0) begin
                    check("dut0_unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q0.pop_front();
                    check("dut0_word", s0_pdata, e);
                end
                xfer_q.push_back(cyc);
            end
            prev_stall0 = s0_pvalid && !s0_pready;
            prev_data0  = s0_pdata;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && s1_pvalid && s1_pready) begin
            if (exp_q1.size() == 0) begin
                check("dut1_unexpected_word", 32'd1, 32'd0);
            end else begin
                e = exp_q1.pop_front();
                check("dut1_word", s1_pdata, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int         t0;
        logic [3:0] seq;
        rst = 1'b1;
        s0_data = 1'b0; s0_valid = 1'b0; s0_pready = 1'b0;
        s1_data = 1'b0; s1_valid = 1'b0; s1_pready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_par_valid", s0_pvalid, 32'd0);
        check("rst_par_data",  s0_pdata,  32'd0);
        check("rst_bit_cnt",   s0_cnt,    32'd0);
        check("rst_ser_ready", s0_ready,  32'd0);
        check("rst_state",     s0_state,  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_ser_ready", s0_ready, 32'd1);

        // Single word LSB first: 1,1,0,1 -> 11, with bit_cnt 0,1,2,3,0
        s0_pready = 1'b1;
        seq = 4'b1011;
        exp_q0.push_back(4'd11);
        for (int k = 0; k < 4; k++) begin
            check("single_bit_cnt", s0_cnt, k);
            check("single_no_early_valid", s0_pvalid, 32'd0);
            send_bit(0, seq[k]);
        end
        check("single_valid", s0_pvalid, 32'd1);
        check("single_data",  s0_pdata,  32'd11);
        check("single_cnt_wrap", s0_cnt, 32'd0);
        @(posedge clk); #1;
        check("single_valid_falls", s0_pvalid, 32'd0);

        // MSB first: 1,1,1,0 -> 14, sent back-to-back and then with gaps
        exp_q1.push_back(4'd14);
        send_seq(1, 4'b0111, 0);
        check("msb_valid", s1_pvalid, 32'd1);
        check("msb_data",  s1_pdata,  32'd14);
        exp_q1.push_back(4'd14);
        seq = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            send_bit(1, seq[k]);
            if (k < 3) repeat (3) begin
                @(posedge clk); #1;
                check("msb_gap_no_valid", s1_pvalid, 32'd0);
            end
        end
        check("msb_gap_valid", s1_pvalid, 32'd1);
        check("msb_gap_data",  s1_pdata,  32'd14);
        @(posedge clk); #1;

        // Backpressure: 7 then 11 with par_ready low
        s0_pready = 1'b0;
        exp_q0.push_back(4'd7);
        exp_q0.push_back(4'd11);
        send_seq(0, 4'b0111, 0);
        check("bp_first_valid", s0_pvalid, 32'd1);
        check("bp_first_data",  s0_pdata,  32'd7);
        send_seq(0, 4'b1011, 0);
        check("bp_hold_state",     s0_state, 32'd1);
        check("bp_hold_ser_ready", s0_ready, 32'd0);
        check("bp_hold_data",      s0_pdata, 32'd7);
        check("bp_hold_cnt",       s0_cnt,   32'd0);
        repeat (2) begin @(posedge clk); #1; end
        check("bp_still_hold", s0_ready, 32'd0);
        s0_pready = 1'b1;
        @(posedge clk); #1;
        s0_pready = 1'b0;
        check("bp_reload_data",  s0_pdata,  32'd11);
        check("bp_reload_valid", s0_pvalid, 32'd1);
        check("bp_ser_ready",    s0_ready,  32'd1);
        check("bp_state",        s0_state,  32'd0);
        s0_pready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", s0_pvalid, 32'd0);

        // Full throughput: 7, 11, 14 back to back with par_ready high
        xfer_q.delete();
        stall_cnt = 0;
        exp_q0.push_back(4'd7);
        exp_q0.push_back(4'd11);
        exp_q0.push_back(4'd14);
        t0 = cyc;
        send_seq(0, 4'b0111, 0);
        send_seq(0, 4'b1011, 0);
        send_seq(0, 4'b1110, 0);
        check("tp_cycles", cyc - t0, 32'd12);
        check("tp_no_stall", stall_cnt, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        check("tp_xfer_count", xfer_q.size(), 32'd3);
        if (xfer_q.size() == 3) begin
            check("tp_spacing_a", xfer_q[1] - xfer_q[0], 32'd4);
            check("tp_spacing_b", xfer_q[2] - xfer_q[1], 32'd4);
        end

        // Last bit of 14 accepted on the same edge that 11 is taken
        s0_pready = 1'b0;
        exp_q0.push_back(4'd11);
        send_seq(0, 4'b1011, 0);
        exp_q0.push_back(4'd14);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        check("sim_pre_data", s0_pdata, 32'd11);
        s0_pready = 1'b1;
        send_bit(0, 1'b1);
        check("sim_data",  s0_pdata,  32'd14);
        check("sim_valid", s0_pvalid, 32'd1);
        check("sim_state", s0_state,  32'd0);
        check("sim_ready", s0_ready,  32'd1);
        @(posedge clk); #1;
        s0_pready = 1'b0;
        check("sim_drained", s0_pvalid, 32'd0);

        // Asynchronous reset mid-word with a word held in the output register
        exp_q0.push_back(4'd7);
        send_seq(0, 4'b0111, 0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        check("mid_cnt", s0_cnt, 32'd2);
        check("mid_valid_before", s0_pvalid, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_par_valid", s0_pvalid, 32'd0);
        check("async_bit_cnt",   s0_cnt,    32'd0);
        check("async_par_data",  s0_pdata,  32'd0);
        check("async_ser_ready", s0_ready,  32'd0);
        exp_q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_rst_ser_ready", s0_ready, 32'd1);
        check("after_rst_cnt",       s0_cnt,   32'd0);

        // A fresh word after reset must not carry the discarded partial bits
        s0_pready = 1'b1;
        exp_q0.push_back(4'd5);
        send_seq(0, 4'b0101, 0);
        check("post_rst_data", s0_pdata, 32'd5);
        repeat (2) begin @(posedge clk); #1; end

        check("q0_empty", exp_q0.size(), 32'd0);
        check("q1_empty", exp_q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/s2p_converter.md
Name: s2p_converter

Overview:
- Serial-to-parallel deserialiser. Sits directly downstream of the parallel-to-serial converter.
- Consumes its ser_data/ser_valid/ser_ready stream and reassembles N-bit words.
- Presents each word on a valid/ready parallel interface.
- Holds one completed word in the output register and a second in the shift register, so the serial side keeps full throughput under short parallel-side stalls.

Parameters:
- N, 4, word width in bits (N >= 2).
- MSB_FIRST, 0. 0: first serial bit received is par_data[0] (LSB first). 1: first bit is par_data[N-1].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state immediately on assertion; released synchronously by the system.
- ser_data  input  1  serial data bit.
- ser_valid  input  1  ser_data is valid this cycle.
- ser_ready  output  1  block accepts a serial bit this cycle.
- par_data  output  N  reassembled word; stable while par_valid=1 and par_ready=0.
- par_valid  output  1  par_data holds a complete word.
- par_ready  input  1  downstream accepts par_data this cycle.
- bit_cnt  output  $clog2(N)  number of bits collected toward the current word (debug/status).

Behaviour:
- Reset values: ser_ready=0 while rst=1, then 1 from the first cycle after release. par_valid=0, par_data=0, bit_cnt=0, state=COLLECT. Shift register is cleared.
- Handshakes:
  - Serial bit accepted on a rising edge with ser_valid & ser_ready.
  - Word transferred on a rising edge with par_valid & par_ready.
  - No combinational path from par_ready to ser_ready; ser_ready is decoded from registered state only.
- Shift register assembly:
  - MSB_FIRST=0: bit k of a word lands in position k.
  - MSB_FIRST=1: bit k lands in position N-1-k.
  - bit_cnt increments per accepted bit and wraps N-1 -> 0 on the last bit.
- FSM states:
  - COLLECT: ser_ready=1.
  - HOLD: ser_ready=0; shift register holds a complete word awaiting the output slot.
- COLLECT, accepting a non-last bit: shift it in, bit_cnt+1.
- COLLECT, accepting the last bit (bit_cnt=N-1):
  - If the output slot is free (par_valid=0, or par_valid & par_ready this cycle): the completed word, including this bit, loads into par_data. par_valid=1 on the next cycle, bit_cnt=0, stay in COLLECT.
  - Else: store the completed word in the shift register, bit_cnt=0, go to HOLD.
- HOLD: when par_valid & par_ready, load the shift register into par_data. par_valid stays 1, shift register clears, go to COLLECT. Otherwise remain in HOLD.
- par_valid falls only after a transfer that does not reload in the same edge.
- Latency: the word is valid the cycle after its last bit is accepted, provided the slot is free. Back-to-back words give zero idle serial cycles.
- ser_valid=0 mid-word: bits already collected are kept indefinitely; no timeout.
- Reset mid-word or in HOLD: partial and held words are discarded; par_valid drops asynchronously.
- Last-bit accept and par transfer on the same edge: the new word replaces the old. par_valid stays 1 with no bubble.
- X on ser_data while ser_valid=0 must not propagate into par_data.

Test Plan:
- Reset behaviour: assert rst mid-cycle with bit_cnt=2 -> par_valid, bit_cnt and par_data go to 0 immediately; ser_ready=1 the cycle after release.
- Single word, N=4, MSB_FIRST=0, par_ready=1: send bits 1,1,0,1 on consecutive cycles -> par_data=4'd11 with par_valid high exactly one cycle after the 4th bit; bit_cnt sequence 0,1,2,3,0.
- MSB_FIRST=1: send 1,1,1,0 -> par_data=4'd14. Gapped ser_valid (gaps of 3 cycles between bits) -> same result, and no par_valid before the 4th bit.
- Backpressure:
  - Setup: par_ready=0; stream words 7 then 11 continuously.
  - After word 7: par_data=7 and par_valid=1, held stable.
  - After word 11's last bit: state HOLD, ser_ready=0.
  - Raise par_ready for one cycle: 7 transferred, par_data=11 next cycle, ser_ready=1 again.
- Full throughput with par_ready=1: stream 7, 11, 14 back-to-back (12 bits in 12 cycles) -> ser_ready never low; three par transfers spaced exactly 4 cycles apart.
- Simultaneous event: last bit of word 14 accepted on the same edge word 11 is taken -> par_data switches 11 -> 14 with par_valid continuously 1; no HOLD entry.
